// File: rtl/sixteen_bit_sequential_dadda_controller.sv
// Sequential 16x16 unsigned multiplier built around one 8x8 Dadda multiplier.
// The 8x8 unit is reused over four cycles, and each byte product is summed
// into a 32-bit accumulator. Operands come in and the result goes out over
// valid/ready handshakes.
// Optional build macro: ZERO_SKIP_EN. When it is defined, an operation with a
// zero operand goes straight from IDLE to DONE with a zero result.

module eight_bit_accurate_dadda_multiplier (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    assign p = {8'd0, a} * {8'd0, b};
endmodule

module sixteen_bit_sequential_dadda_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      in1,
    input  logic [15:0]      in2,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] done_count
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]  state;
    logic [1:0]  step;
    logic [15:0] a_r;
    logic [15:0] b_r;
    logic [31:0] acc;
    logic [7:0]  sel_a;
    logic [7:0]  sel_b;
    logic [15:0] pp;
    logic [31:0] pp_shift;

    eight_bit_accurate_dadda_multiplier u_mul8 (
        .a (sel_a),
        .b (sel_b),
        .p (pp)
    );

    // Choose operand bytes from the registered operands and align the byte product for this step
    always_comb begin
        sel_a    = step[1] ? a_r[15:8] : a_r[7:0];
        sel_b    = step[0] ? b_r[15:8] : b_r[7:0];
        pp_shift = {8'd0, pp, 8'd0};
        case (step)
            2'd0:    pp_shift = {16'd0, pp};
            2'd3:    pp_shift = {pp, 16'd0};
            default: pp_shift = {8'd0, pp, 8'd0};
        endcase
    end

    // Control FSM, operand capture, accumulation and delivered-result counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            step       <= 2'd0;
            a_r        <= 16'd0;
            b_r        <= 16'd0;
            acc        <= 32'd0;
            done_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r  <= in1;
                        b_r  <= in2;
                        acc  <= 32'd0;
                        step <= 2'd0;
`ifdef ZERO_SKIP_EN
                        if (in1 == 16'd0 || in2 == 16'd0)
                            state <= DONE;
                        else
                            state <= MUL;
`else
                        state <= MUL;
`endif
                    end
                end
                MUL: begin
                    acc  <= acc + pp_shift;
                    step <= step + 2'd1;
                    if (step == 2'd3)
                        state <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                        if (done_count != CNT_MAX)
                            done_count <= done_count + CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == MUL);
    assign out_valid = (state == DONE);
    assign out       = acc;

endmodule

// File: doc/sixteen_bit_sequential_dadda_controller.md
Name: sixteen_bit_sequential_dadda_controller

Overview:
Time-multiplexed 16x16 unsigned multiplier. It sequences a single eight_bit_accurate_dadda_multiplier instance over four partial-product steps instead of using four instances in parallel. Partial products are accumulated into a 32-bit result register. It trades area for latency and sits where a full sixteen-bit Dadda array is too large. Operands and results move over valid/ready handshakes.

Parameters:
CNT_W, 16, width of the saturating completed-operation counter done_count.

Ports:
clk  input  1  sole clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in1  input  16  multiplicand; sampled only on input handshake
in2  input  16  multiplier; sampled only on input handshake
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
out  output  32  product in1*in2 (unsigned)
out_valid  output  1  out holds a completed product
out_ready  input  1  consumer accepts out
busy  output  1  high in MUL state
done_count  output  CNT_W  number of products delivered, saturating

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, step=0, operand regs=0, accumulator=0. Outputs: out=0, out_valid=0, in_ready=1 (IDLE), busy=0, done_count=0. Reset has priority over every other event, including mid-MUL and DONE; any in-flight operation is discarded with no output.
- States: IDLE, MUL, DONE.
- IDLE: in_ready=1. If in_valid=1, latch in1/in2, clear accumulator, step<=0, go to MUL. Otherwise stay in IDLE.
- MUL: in_ready=0, busy=1. Each cycle, one 8x8 product p (16 bits) is added into the 32-bit accumulator:
  - step0: in1[7:0]*in2[7:0], added unshifted
  - step1: in1[7:0]*in2[15:8], shifted left 8
  - step2: in1[15:8]*in2[7:0], shifted left 8
  - step3: in1[15:8]*in2[15:8], shifted left 16
  - After step3, go to DONE. Accumulator addition is full 32-bit and cannot overflow (max 0xFFFE0001).
- DONE: out_valid=1, out=accumulator, in_ready=0. out is stable while out_valid=1 and out_ready=0. On out_ready=1: out_valid<=0, done_count increments (holds at 2^CNT_W-1 once saturated), go to IDLE.
- No overlap: a new operand is not accepted in the same cycle a result is consumed. in_ready rises the cycle after the DONE->IDLE transition.
- Latency: handshake at edge N; step0..step3 at edges N+1..N+4; out_valid=1 after edge N+4. Minimum issue interval is 6 cycles with out_ready held high.
- Operand inputs changing during MUL or DONE have no effect.
- in_valid asserted while in_ready=0 is ignored, not queued.
- The 8x8 multiplier is combinational; operand byte selection is a mux driven by step, and the mux inputs come from registers only.

Optional Feature:
ZERO_SKIP_EN:
- Defined: in IDLE, if in_valid=1 and either in1==0 or in2==0, go directly to DONE with accumulator=0 and skip MUL. out_valid=1 after the edge following the handshake, and busy never asserts for that operation.
- Undefined: zero operands take the full 4-step MUL path, so latency is identical for all operands.

Test Plan:
- Reset, then in1=0x1234, in2=0x5678 with in_valid pulse, out_ready=1 -> out_valid after exactly 5 edges, out=0x06260060, done_count=1, in_ready back high next cycle.
- in1=0xFFFF, in2=0xFFFF -> out=0xFFFE0001. Hold out_ready=0 for 3 cycles -> out and out_valid stable, in_ready=0, and an in_valid pulse in that window is ignored (no second result appears).
- Assert rst at step2 of a MUL -> next cycle state IDLE, out=0, out_valid=0, done_count unchanged-to-0, in_ready=1. A following 0x0003*0x0005 gives 0x0000000F.
- in1=0x0000, in2=0xABCD:
  - ZERO_SKIP_EN defined -> out_valid 1 cycle after the handshake, out=0, busy never 1.
  - Undefined -> 5-cycle latency, out=0.
- Override CNT_W=2 and run 5 back-to-back operations (0x00FF*0x0100=0x0000FF00 each) -> done_count reads 1,2,3,3,3.
- Randomized 1000 operand pairs with random out_ready stalls -> every out equals the reference in1*in2, one result per accepted input, in order.
